// File: rtl/viterbi_pkg.sv
// Types and default code parameters shared by the K=3 convolutional encoder
// and the Viterbi decoder's branch-metric unit.
package viterbi_pkg;
  localparam int         K_DEF  = 3;
  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  typedef logic [1:0] code_sym_t;

  typedef enum logic {DATA, TAIL} enc_state_t;
endpackage

// File: rtl/conv_enc_parity.sv
// Combinational window-to-symbol map: sym = {parity(window & G1), parity(window & G0)}.
// The decoder's expected-symbol generator uses the same map.
module conv_enc_parity
  import viterbi_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic [K-1:0] window,
  output code_sym_t    sym
);
  assign sym = {^(window & G1), ^(window & G0)};
endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 feed-forward convolutional encoder, K-1 zero tail bits per frame.
// Optional CONV_ENC_ERRINJ_EN adds err_mask[1:0], which is XORed into each loaded symbol.
module conv_encoder_k3
  import viterbi_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  input  logic      in_bit,
  input  logic      in_last,
  output logic      in_ready,
  output logic      out_valid,
  output code_sym_t out_sym,
  output logic      out_last,
  input  logic      out_ready,
`ifdef CONV_ENC_ERRINJ_EN
  input  logic [1:0] err_mask,
`endif
  output logic      busy
);
  localparam int           TW       = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [TW-1:0] TAIL_END = TW'(K - 2);

  enc_state_t    state;
  logic [K-2:0]  sr;
  logic [TW-1:0] tail_cnt;

  logic          adv_p0;
  logic          load_p0;
  logic          u_p0;
  logic          tail_end_p0;
  logic [K-1:0]  win_p0;
  code_sym_t     sym_p0;
  code_sym_t     err_p0;

  code_sym_t     sym_p1;
  logic          vld_p1;
  logic          last_p1;

  // Stage 0: window formation, parity and load decision
  assign adv_p0      = ~vld_p1 | out_ready;
  assign in_ready    = (state == DATA) & adv_p0;
  assign load_p0     = (state == DATA) ? (in_valid & adv_p0) : adv_p0;
  assign u_p0        = (state == DATA) ? in_bit : 1'b0;
  assign win_p0      = {u_p0, sr};
  assign tail_end_p0 = (state == TAIL) & (tail_cnt == TAIL_END);

`ifdef CONV_ENC_ERRINJ_EN
  assign err_p0 = err_mask;
`else
  assign err_p0 = '0;
`endif

  conv_enc_parity #(.K(K), .G0(G0), .G1(G1)) u_parity (
    .window (win_p0),
    .sym    (sym_p0)
  );

  // Stage 1: single output register; the shift register always advances on
  // the uncorrupted window so injected errors never reach the encoder state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= DATA;
      sr       <= '0;
      tail_cnt <= '0;
      vld_p1   <= 1'b0;
      sym_p1   <= '0;
      last_p1  <= 1'b0;
    end else begin
      if (load_p0) begin
        sym_p1  <= sym_p0 ^ err_p0;
        vld_p1  <= 1'b1;
        last_p1 <= tail_end_p0;
        sr      <= win_p0[K-1:1];
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end

      case (state)
        DATA: begin
          if (load_p0 && in_last) begin
            state    <= TAIL;
            tail_cnt <= '0;
          end
        end
        TAIL: begin
          if (load_p0) begin
            if (tail_end_p0) begin
              state    <= DATA;
              tail_cnt <= '0;
            end else begin
              tail_cnt <= tail_cnt + TW'(1);
            end
          end
        end
        default: state <= DATA;
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign out_sym   = sym_p1;
  assign out_last  = last_p1;
  assign busy      = (state == TAIL) | vld_p1;
endmodule

// File: tb/tb_conv_encoder_k3.sv
// Self-checking bench for conv_encoder_k3: randomized frames and back-pressure
// checked against a generator-polynomial convolution model.
module tb_conv_encoder_k3;
  localparam int         K  = 3;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_sym;
  logic       out_last;
  logic       busy;
`ifdef CONV_ENC_ERRINJ_EN
  logic [1:0] err_mask = 2'b00;
  int         err_idx = -1;
  logic [1:0] err_val = 2'b00;
`endif

  int checks = 0;
  int errors = 0;

  bit         bits_q[$];
  bit         last_q[$];
  logic [1:0] exp_sym[$];
  bit         exp_last[$];
  logic [1:0] got_sym[$];
  bit         got_last[$];
  int         got_cyc[$];
  int         stall_bad;
  int         inrdy_bad;
  bit         timed_out;

  always #5 clk = ~clk;

  conv_encoder_k3 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sym   (out_sym),
    .out_last  (out_last),
    .out_ready (out_ready),
`ifdef CONV_ENC_ERRINJ_EN
    .err_mask  (err_mask),
`endif
    .busy      (busy)
  );

  // Convolution of the bit history with the generators: sym_j = XOR_k G_j[K-1-k] * x[n-k]
  function automatic logic [1:0] model_sym(input bit h[$]);
    logic s0 = 1'b0;
    logic s1 = 1'b0;
    int   n  = h.size() - 1;
    for (int k = 0; k < K; k++) begin
      bit x;
      x = (n - k >= 0) ? h[n-k] : 1'b0;
      if (G0[K-1-k]) s0 ^= x;
      if (G1[K-1-k]) s1 ^= x;
    end
    return {s1, s0};
  endfunction

  function automatic void build_expected();
    bit hist[$];
    exp_sym.delete();
    exp_last.delete();
    for (int i = 0; i < bits_q.size(); i++) begin
      hist.push_back(bits_q[i]);
      exp_sym.push_back(model_sym(hist));
      exp_last.push_back(1'b0);
      if (last_q[i]) begin
        for (int t = 0; t < K - 1; t++) begin
          hist.push_back(1'b0);
          exp_sym.push_back(model_sym(hist));
          exp_last.push_back(t == K - 2);
        end
        hist.delete();
      end
    end
  endfunction

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // mode 0: out_ready always 1; mode 1: 1,0,0 repeating; mode 2: random ready and input gaps
  task automatic run_stream(input int mode, input int budget);
    int         idx = 0;
    int         cyc = 0;
    bit         prev_stall = 1'b0;
    logic [1:0] prev_sym = 2'b00;
    bit         prev_last = 1'b0;
    got_sym.delete();
    got_last.delete();
    got_cyc.delete();
    stall_bad = 0;
    inrdy_bad = 0;
    while (got_sym.size() < exp_sym.size() && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (idx < bits_q.size()) begin
        in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_bit   = bits_q[idx];
        in_last  = last_q[idx];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        in_last  = 1'($urandom);
      end
`ifdef CONV_ENC_ERRINJ_EN
      err_mask = (idx == err_idx) ? err_val : 2'b00;
`endif
      #1;
      if (prev_stall && (out_valid !== 1'b1 || out_sym !== prev_sym || out_last !== prev_last))
        stall_bad++;
      if (out_valid && !out_ready && in_ready !== 1'b0)
        inrdy_bad++;
      if (out_valid && out_ready) begin
        got_sym.push_back(out_sym);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) idx++;
      prev_stall = out_valid && !out_ready;
      prev_sym   = out_sym;
      prev_last  = out_last;
      cyc++;
    end
    timed_out = (got_sym.size() < exp_sym.size());
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b0;
`ifdef CONV_ENC_ERRINJ_EN
      err_mask  = 2'b00;
`endif
      #1;
      if (out_valid) begin
        got_sym.push_back(out_sym);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc + d);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sym !== 2'b00) begin errors++; $display("FAIL reset_out_sym: got %b expected 00", out_sym); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    apply_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic_frame();
    logic [1:0] table_sym[6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    bits_q = '{1, 0, 1, 1};
    last_q = '{0, 0, 0, 1};
    build_expected();
    run_stream(0, 200);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got %0d symbols expected 6", got_sym.size()); end
    checks++; if (got_sym.size() != 6) begin errors++; $display("FAIL basic_count: got %0d expected 6", got_sym.size()); end
    for (int i = 0; i < 6 && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== table_sym[i] || got_sym[i] !== exp_sym[i]) begin
        errors++; $display("FAIL basic_sym[%0d]: got %b expected %b", i, got_sym[i], table_sym[i]);
      end
      checks++;
      if (got_last[i] !== (i == 5)) begin
        errors++; $display("FAIL basic_last[%0d]: got %b expected %b", i, got_last[i], (i == 5));
      end
    end
    checks++;
    if (got_cyc.size() == 6 && got_cyc[5] - got_cyc[0] != 5) begin
      errors++; $display("FAIL basic_throughput: got span %0d expected 5", got_cyc[5] - got_cyc[0]);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    bits_q = '{1, 0, 1, 1};
    last_q = '{0, 0, 0, 1};
    build_expected();
    run_stream(1, 400);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got %0d symbols expected %0d", got_sym.size(), exp_sym.size()); end
    checks++; if (got_sym.size() != exp_sym.size()) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_sym.size(), exp_sym.size()); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", stall_bad); end
    checks++; if (inrdy_bad != 0) begin errors++; $display("FAIL bp_in_ready: got %0d stall cycles with in_ready=1 expected 0", inrdy_bad); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL bp_sym[%0d]: got %b/%b expected %b/%b", i, got_sym[i], got_last[i], exp_sym[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bits_q = '{1, 0};
    last_q = '{1, 1};
    build_expected();
    run_stream(0, 200);
    checks++; if (got_sym.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", got_sym.size()); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL b2b_sym[%0d]: got %b/%b expected %b/%b", i, got_sym[i], got_last[i], exp_sym[i], exp_last[i]);
      end
    end
    checks++;
    if (got_cyc.size() == 6 && got_cyc[5] - got_cyc[0] != 5) begin
      errors++; $display("FAIL b2b_no_bubble: got span %0d expected 5", got_cyc[5] - got_cyc[0]);
    end
  endtask

  task automatic test_reset_mid_tail();
    bit seq[4] = '{1, 0, 1, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_bit    = seq[i];
      in_last   = (i == 3);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_sym !== 2'b10 || out_last !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midtail_pre: got v=%b sym=%b last=%b busy=%b rdy=%b expected v=1 sym=10 last=0 busy=1 rdy=0",
                         out_valid, out_sym, out_last, busy, in_ready);
    end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midtail_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midtail_state: got busy=%b rdy=%b expected busy=0 rdy=1", busy, in_ready); end
    @(negedge clk);
    reset = 1'b0;
    bits_q = '{1};
    last_q = '{1};
    build_expected();
    run_stream(0, 200);
    checks++; if (got_sym.size() != 3) begin errors++; $display("FAIL midtail_count: got %0d expected 3", got_sym.size()); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL midtail_sym[%0d]: got %b/%b expected %b/%b", i, got_sym[i], got_last[i], exp_sym[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_all_ones();
    bits_q.delete();
    last_q.delete();
    for (int i = 0; i < 8; i++) begin
      bits_q.push_back(1'b1);
      last_q.push_back(i == 7);
    end
    build_expected();
    run_stream(0, 200);
    checks++; if (got_sym.size() != 10) begin errors++; $display("FAIL ones_count: got %0d expected 10", got_sym.size()); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL ones_sym[%0d]: got %b/%b expected %b/%b", i, got_sym[i], got_last[i], exp_sym[i], exp_last[i]);
      end
    end
    checks++;
    if (got_cyc.size() == 10 && got_cyc[9] - got_cyc[0] != 9) begin
      errors++; $display("FAIL ones_throughput: got span %0d expected 9", got_cyc[9] - got_cyc[0]);
    end
  endtask

  task automatic test_random_frames();
    bits_q.delete();
    last_q.delete();
    for (int f = 0; f < 5; f++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        bits_q.push_back(1'($urandom));
        last_q.push_back(i == len - 1);
      end
    end
    build_expected();
    run_stream(2, 4000);
    checks++; if (timed_out) begin errors++; $display("FAIL rand_timeout: got %0d symbols expected %0d", got_sym.size(), exp_sym.size()); end
    checks++; if (got_sym.size() != exp_sym.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_sym.size(), exp_sym.size()); end
    checks++; if (stall_bad != 0 || inrdy_bad != 0) begin errors++; $display("FAIL rand_backpressure: got %0d/%0d violations expected 0/0", stall_bad, inrdy_bad); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL rand_sym[%0d]: got %b/%b expected %b/%b", i, got_sym[i], got_last[i], exp_sym[i], exp_last[i]);
      end
    end
  endtask

`ifdef CONV_ENC_ERRINJ_EN
  task automatic test_err_inject();
    bits_q = '{1, 0, 1, 1};
    last_q = '{0, 0, 0, 1};
    build_expected();
    err_idx = 1;
    err_val = 2'b01;
    exp_sym[1] = exp_sym[1] ^ err_val;
    run_stream(0, 200);
    err_idx = -1;
    checks++; if (got_sym.size() != 6) begin errors++; $display("FAIL err_count: got %0d expected 6", got_sym.size()); end
    for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL err_sym[%0d]: got %b/%b expected %b/%b", i, got_sym[i], got_last[i], exp_sym[i], exp_last[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_tail();
    test_all_ones();
    test_random_frames();
`ifdef CONV_ENC_ERRINJ_EN
    test_err_inject();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
